// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_INPUTS AXI-Stream sources onto one sink.
// A grant is held from the first beat through TLAST; packets never interleave.
module axis_packet_arbiter #(
    parameter int DW         = 512,
    parameter int NUM_INPUTS = 4,
    parameter int CW         = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS*DW-1:0]        s_axis_tdata,
    input  logic [NUM_INPUTS*DW/8-1:0]      s_axis_tkeep,
    input  logic [NUM_INPUTS-1:0]           s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]           s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]           s_axis_tready,
    output logic [DW-1:0]                   m_axis_tdata,
    output logic [DW/8-1:0]                 m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(NUM_INPUTS)-1:0]   grant,
    output logic                            busy,
    output logic [NUM_INPUTS*CW-1:0]        pkt_count
);
    localparam int GW = $clog2(NUM_INPUTS);
    localparam int KW = DW / 8;

    typedef enum logic {ARB, PASS} state_t;

    state_t        state;
    logic          beat_acc;
    logic          last_acc;
    logic [CW-1:0] cnt [NUM_INPUTS];

    // Scan last+1, last+2, ... wrapping; the previous winner itself is checked last.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] last,
                                              input logic [NUM_INPUTS-1:0] req);
        logic [GW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (req[idx[GW-1:0]]) pick = GW'(idx);
        end
        return pick;
    endfunction

    assign m_axis_tdata  = s_axis_tdata[grant*DW +: DW];
    assign m_axis_tkeep  = s_axis_tkeep[grant*KW +: KW];
    assign m_axis_tlast  = s_axis_tlast[grant];
    assign m_axis_tvalid = (state == PASS) && !reset && s_axis_tvalid[grant];

    always_comb begin
        s_axis_tready = '0;
        if (state == PASS && !reset) s_axis_tready[grant] = m_axis_tready;
    end

    assign beat_acc = m_axis_tvalid && m_axis_tready;
    assign last_acc = beat_acc && m_axis_tlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
            grant <= GW'(NUM_INPUTS - 1);
            busy  <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|s_axis_tvalid) begin
                        grant <= rr_pick(grant, s_axis_tvalid);
                        state <= PASS;
                        busy  <= 1'b1;
                    end
                end
                PASS: begin
                    // A source stalling mid-packet keeps the grant indefinitely.
                    if (last_acc) begin
                        state      <= ARB;
                        busy       <= 1'b0;
                        cnt[grant] <= cnt[grant] + CW'(1);
                    end
                end
                default: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
        assign pkt_count[i*CW +: CW] = cnt[i];
    end

endmodule
